jtopl_wrq: RTL and testbench



---
 rtl/jtopl_wrq.sv | 162 ++++++++++++++++
 tb/tb_jtopl_wrq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtopl_wrq.sv
// Host-side write queue for the OPL CPU bus: buffers {reg,val} pairs and replays
// them as address/data strobes separated by the chip's cen-counted recovery waits.
module jtopl_wrq #(
  parameter int unsigned AW        = 4,
  parameter int unsigned ADDR_WAIT = 12,
  parameter int unsigned DATA_WAIT = 84
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [7:0]    req_reg,
  input  logic [7:0]    req_val,
  input  logic          flush,
  output logic [7:0]    opl_din,
  output logic          opl_addr,
  output logic          opl_cs_n,
  output logic          opl_wr_n,
  output logic          busy,
  output logic [AW:0]   level
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned MAXW  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int unsigned CW    = $clog2(MAXW + 1);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT_A, DATA, WAIT_D} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [7:0]      val_q, val_nxt;
  logic [7:0]      din_nxt;
  logic            addr_nxt;
  logic            strobe_n_nxt;
  logic            pop;
  logic            push;

  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     level_nxt;
  logic [15:0]     head;

  assign head = mem[rd_ptr];
  assign push = req_valid && req_ready && !flush;
  assign busy = (level != '0) || (state != IDLE);

  // Queue bookkeeping; level is kept separately so full and empty are distinct.
  always_comb begin
    level_nxt = level;
    if (flush)
      level_nxt = '0;
    else if (push && !pop)
      level_nxt = level + 1'b1;
    else if (pop && !push)
      level_nxt = level - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {req_reg, req_val};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      req_ready <= 1'b1;
    end else begin
      level     <= level_nxt;
      req_ready <= (level_nxt != (AW+1)'(DEPTH));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Bus outputs are computed alongside the next state and registered with it,
  // so the strobe appears on the same edge the FSM enters ADDR/DATA.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    val_nxt      = val_q;
    din_nxt      = opl_din;
    addr_nxt     = opl_addr;
    strobe_n_nxt = opl_cs_n;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0 && !flush) begin
          pop          = 1'b1;
          state_nxt    = ADDR;
          din_nxt      = head[15:8];
          val_nxt      = head[7:0];
          addr_nxt     = 1'b0;
          strobe_n_nxt = 1'b0;
        end
      end
      ADDR: begin
        if (cen) begin
          state_nxt    = WAIT_A;
          cnt_nxt      = CW'(ADDR_WAIT - 1);
          strobe_n_nxt = 1'b1;
        end
      end
      WAIT_A: begin
        if (cen) begin
          if (cnt == '0) begin
            state_nxt    = DATA;
            din_nxt      = val_q;
            addr_nxt     = 1'b1;
            strobe_n_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
      end
      DATA: begin
        if (cen) begin
          state_nxt    = WAIT_D;
          cnt_nxt      = CW'(DATA_WAIT - 1);
          strobe_n_nxt = 1'b1;
        end
      end
      WAIT_D: begin
        if (cen) begin
          if (cnt == '0)
            state_nxt = IDLE;
          else
            cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      val_q    <= '0;
      opl_din  <= '0;
      opl_addr <= 1'b0;
      opl_cs_n <= 1'b1;
      opl_wr_n <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      val_q    <= val_nxt;
      opl_din  <= din_nxt;
      opl_addr <= addr_nxt;
      opl_cs_n <= strobe_n_nxt;
      opl_wr_n <= strobe_n_nxt;
    end
  end

endmodule

// File: tb/tb_jtopl_wrq.sv
// Directed bench for jtopl_wrq: strobe timing, fill/backpressure, ordering, flush, async reset.
module tb_jtopl_wrq;
  logic       clk = 1'b0;
  logic       rst_n, cen, req_valid, req_ready, flush;
  logic [7:0] req_reg, req_val, opl_din;
  logic       opl_addr, opl_cs_n, opl_wr_n, busy;
  logic [4:0] level;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cen_mode = 1;
  int ph = 0;
  logic [8:0] log_q[$];
  int a_start = 0, a_end = 0, d_start = 0, d_end = 0, busy_fall = 0;
  logic prev_cs = 1'b1;
  logic prev_busy = 1'b0;

  jtopl_wrq #(.AW(4), .ADDR_WAIT(12), .DATA_WAIT(84)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_val(req_val), .flush(flush),
    .opl_din(opl_din), .opl_addr(opl_addr), .opl_cs_n(opl_cs_n), .opl_wr_n(opl_wr_n),
    .busy(busy), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // cen_mode: 0 = stalled, 1 = every clk, 4 = every 4th clk
  always @(negedge clk) begin
    ph  = (ph + 1) % 4;
    cen = (cen_mode == 1) || (cen_mode == 4 && ph == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: logs each write as {addr,din} and stamps edges in clk cycles.
  always @(negedge clk) begin
    if (prev_cs && !opl_cs_n) begin
      log_q.push_back({opl_addr, opl_din});
      if (opl_addr) d_start = cyc; else a_start = cyc;
      chk("wr_n_with_cs", {31'd0, opl_wr_n}, 32'd0);
    end
    if (!prev_cs && opl_cs_n) begin
      if (opl_addr) d_end = cyc; else a_end = cyc;
    end
    if (prev_busy && !busy) busy_fall = cyc;
    prev_cs   = opl_cs_n;
    prev_busy = busy;
  end

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic push_one(input logic [7:0] r, input logic [7:0] v);
    int n = 0;
    req_reg = r; req_val = v; req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("push_timeout", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc, n, w;
    logic [7:0] r, v;
    rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; req_reg = '0; req_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'd0, opl_cs_n}, 1);
    chk("rst_wr_n", {31'd0, opl_wr_n}, 1);
    chk("rst_addr", {31'd0, opl_addr}, 0);
    chk("rst_din", {24'd0, opl_din}, 0);
    chk("rst_ready", {31'd0, req_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_level", {27'd0, level}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single write, cen every clk
    log_q.delete();
    req_reg = 8'h20; req_val = 8'h01; req_valid = 1'b1;
    @(negedge clk);
    pc = cyc; req_valid = 1'b0;
    wait_idle(300, "t1_idle");
    chk("t1_nwrites", log_q.size(), 2);
    chk("t1_addr_wr", {23'd0, log_q[0]}, {23'd0, 9'h020});
    chk("t1_data_wr", {23'd0, log_q[1]}, {23'd0, 9'h101});
    chk("t1_latency", a_start - pc, 1);
    chk("t1_a_width", a_end - a_start, 1);
    chk("t1_gap", d_start - a_end, 12);
    chk("t1_d_width", d_end - d_start, 1);
    chk("t1_tail", busy_fall - d_end, 84);

    // single write, cen every 4th clk
    cen_mode = 4;
    log_q.delete();
    push_one(8'h33, 8'h44);
    wait_idle(1000, "t2_idle");
    chk("t2_nwrites", log_q.size(), 2);
    chk("t2_data_wr", {23'd0, log_q[1]}, {23'd0, 9'h144});
    w = a_end - a_start;
    chk("t2_a_width_1to4", {31'd0, (w >= 1 && w <= 4)}, 1);
    chk("t2_gap", d_start - a_end, 48);
    chk("t2_d_width", d_end - d_start, 4);
    chk("t2_tail", busy_fall - d_end, 336);

    // fill with FSM stalled
    cen_mode = 0;
    repeat (2) @(negedge clk);
    log_q.delete();
    for (int k = 0; k < 17; k++) begin
      req_reg = 8'(8'h40 + k); req_val = 8'(8'h80 + k); req_valid = 1'b1;
      @(negedge clk);
    end
    chk("t3_level_full", {27'd0, level}, 16);
    chk("t3_ready_full", {31'd0, req_ready}, 0);
    chk("t3_busy", {31'd0, busy}, 1);
    req_reg = 8'h51; req_val = 8'h91;
    repeat (5) @(negedge clk);
    chk("t3_level_held", {27'd0, level}, 16);
    chk("t3_stuck_strobe", {31'd0, opl_cs_n}, 0);
    chk("t3_stuck_din", {24'd0, opl_din}, 8'h40);
    cen_mode = 1;
    n = 0;
    while (req_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t3_ready_again", {31'd0, req_ready}, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t3_level_refill", {27'd0, level}, 16);
    chk("t3_first_addr", {23'd0, log_q[0]}, {23'd0, 9'h040});
    chk("t3_first_data", {23'd0, log_q[1]}, {23'd0, 9'h180});
    chk("t3_second_addr", {23'd0, log_q[2]}, {23'd0, 9'h041});
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t3_flush_level", {27'd0, level}, 0);
    chk("t3_flush_busy", {31'd0, busy}, 1);
    wait_idle(300, "t3_idle");
    chk("t3_nwrites", log_q.size(), 4);
    chk("t3_second_data", {23'd0, log_q[3]}, {23'd0, 9'h181});

    // ordering and pointer wrap, random offer gaps
    log_q.delete();
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_one(8'(i * 5 + 3), 8'(255 - i * 3));
    end
    wait_idle(6000, "t4_idle");
    chk("t4_nwrites", log_q.size(), 80);
    if (log_q.size() == 80) begin
      for (int i = 0; i < 40; i++) begin
        r = 8'(i * 5 + 3);
        v = 8'(255 - i * 3);
        chk($sformatf("t4_addr_%0d", i), {23'd0, log_q[2*i]}, {23'd0, 1'b0, r});
        chk($sformatf("t4_data_%0d", i), {23'd0, log_q[2*i+1]}, {23'd0, 1'b1, v});
      end
    end

    // flush mid-transaction with 5 queued
    log_q.delete();
    for (int k = 0; k < 6; k++) begin
      req_reg = 8'(8'hA0 + k); req_val = 8'(8'hC0 + k); req_valid = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("t5_level", {27'd0, level}, 5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("t5_flush_level", {27'd0, level}, 0);
    chk("t5_flush_busy", {31'd0, busy}, 1);
    wait_idle(300, "t5_idle");
    chk("t5_nwrites", log_q.size(), 2);
    chk("t5_addr_wr", {23'd0, log_q[0]}, {23'd0, 9'h0A0});
    chk("t5_data_wr", {23'd0, log_q[1]}, {23'd0, 9'h1C0});
    repeat (150) @(negedge clk);
    chk("t5_no_more", log_q.size(), 2);
    chk("t5_busy_low", {31'd0, busy}, 0);

    // async reset during WAIT_A
    for (int k = 0; k < 3; k++) begin
      req_reg = 8'(8'h10 + k); req_val = 8'(8'h20 + k); req_valid = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_level_pre", {27'd0, level}, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cs_n", {31'd0, opl_cs_n}, 1);
    chk("t6_wr_n", {31'd0, opl_wr_n}, 1);
    chk("t6_level", {27'd0, level}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_ready", {31'd0, req_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // async reset while the address strobe is held low (cen stalled)
    cen_mode = 0;
    @(negedge clk);
    push_one(8'h66, 8'h77);
    repeat (2) @(negedge clk);
    chk("t6_strobe_low", {31'd0, opl_cs_n}, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_cs_n", {31'd0, opl_cs_n}, 1);
    chk("t6_async_wr_n", {31'd0, opl_wr_n}, 1);
    chk("t6_async_din", {24'd0, opl_din}, 0);
    @(negedge clk);
    log_q.delete();
    rst_n = 1'b1;
    cen_mode = 1;
    repeat (2) @(negedge clk);
    push_one(8'h55, 8'hAA);
    wait_idle(300, "t6_idle");
    chk("t6_nwrites", log_q.size(), 2);
    chk("t6_addr_wr", {23'd0, log_q[0]}, {23'd0, 9'h055});
    chk("t6_data_wr", {23'd0, log_q[1]}, {23'd0, 9'h1AA});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
